lsu_ooq: RTL

- Parametrised successor to the single-outstanding load/store unit. Sits between EX1 and the dcache/MMU and keeps up to OUTSTANDING dcache requests in flight.
- Per-request format info (low address bits, size, sign, store) is held in an in-order tracker FIFO. Each dcache_data_ok response is extracted and sign-extended with its own request's attributes.
- Adds pipeline flush with discard of in-flight responses, a backpressure-aware MMU hold, and protocol-error detection.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_tracker_fifo.sv | 52 +++++
 rtl/lsu_ooq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and formatting helpers for the out-of-order-tolerant load/store unit.
// Sizes, request op encoding, exception codes and tracker entry layout live here.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic       load;
        logic       store;
        logic [1:0] size;
        logic       sign;
    } lsu_op_t;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_ALE  = 3'd1,
        EXC_TLBR = 3'd2,
        EXC_PIL  = 3'd3,
        EXC_PIS  = 3'd4,
        EXC_PPI  = 3'd5,
        EXC_PME  = 3'd6
    } lsu_excp_t;

    // Everything needed to format a response once the raw word comes back.
    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       sign;
        logic       store;
    } trk_ent_t;

    function automatic logic [3:0] lsu_wstrb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_load_fmt(input logic [31:0] rdata, input trk_ent_t e);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{e.off, 3'b000} +: 8];
        h = e.off[1] ? rdata[31:16] : rdata[15:0];
        if (e.store)
            return 32'h0;
        case (e.size)
            SZ_B:    return {{24{e.sign & b[7]}}, b};
            SZ_H:    return {{16{e.sign & h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_tracker_fifo.sv
// In-order tracker of outstanding requests; head is visible combinationally.
// flush_mark tags every stored entry as discard so its response is swallowed on pop.
module lsu_tracker_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [5:0]
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    input  logic                       flush_mark,
    output logic [$clog2(DEPTH):0]     count,
    output T                           head,
    output logic                       head_discard
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                 mem [DEPTH];
    logic [DEPTH-1:0] discard;
    logic [AW-1:0]    head_ptr;
    logic [AW-1:0]    tail_ptr;
    logic             push_en;
    logic             pop_en;

    assign push_en      = push && (count != CW'(DEPTH));
    assign pop_en       = pop && (count != '0);
    assign head         = mem[head_ptr];
    assign head_discard = discard[head_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            discard  <= '0;
        end else begin
            if (flush_mark)
                discard <= '1;
            if (push_en) begin
                mem[tail_ptr]     <= din;
                discard[tail_ptr] <= 1'b0;
                tail_ptr          <= tail_ptr + AW'(1);
            end
            if (pop_en)
                head_ptr <= head_ptr + AW'(1);
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

endmodule

// File: rtl/lsu_ooq.sv
// Load/store unit keeping up to OUTSTANDING dcache requests in flight between EX1 and dcache/MMU.
// Accept is a zero-cycle handshake; responses are formatted in the same cycle as dc_data_ok.
module lsu_ooq
    import lsu_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int TAG_W       = 20,
    parameter int IDX_W       = 8,
    parameter int OFF_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  lsu_op_t           req_op,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              excp_valid,
    output lsu_excp_t         excp_code,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              busy,
    output logic              protocol_err,
    output logic              mmu_valid,
    output logic [TAG_W-1:0]  mmu_vtag,
    input  logic              mmu_ok,
    input  logic [TAG_W-1:0]  mmu_ptag,
    input  logic [1:0]        mmu_mat,
    input  logic              mmu_fault,
    input  logic              mmu_invalid,
    input  logic              mmu_dirty,
    input  logic              mmu_plv,
    output logic              dc_valid,
    input  logic              dc_addr_ok,
    output logic              dc_store,
    output logic [TAG_W-1:0]  dc_tag,
    output logic [IDX_W-1:0]  dc_index,
    output logic [OFF_W-1:0]  dc_offset,
    output logic [1:0]        dc_size,
    output logic [3:0]        dc_wstrb,
    output logic [31:0]       dc_wdata,
    output logic              dc_uncached,
    input  logic              dc_data_ok,
    input  logic [31:0]       dc_rdata
);
    localparam int CW = $clog2(OUTSTANDING) + 1;

    logic           xlat_held;
    logic           xlat_ok;
    lsu_excp_t      code;
    logic [CW-1:0]  count;
    trk_ent_t       push_ent;
    trk_ent_t       head;
    logic           head_discard;
    logic           pop;

    assign xlat_ok = mmu_ok | xlat_held;

    // Misalignment is known from the address alone, so it wins before translation is back.
    always_comb begin
        code = EXC_NONE;
        if ((req_op.size == SZ_H && req_addr[0]) ||
            (req_op.size == SZ_W && req_addr[1:0] != 2'b00))
            code = EXC_ALE;
        else if (xlat_ok) begin
            if (mmu_fault)                        code = EXC_TLBR;
            else if (mmu_invalid && req_op.load)  code = EXC_PIL;
            else if (mmu_invalid && req_op.store) code = EXC_PIS;
            else if (mmu_plv)                     code = EXC_PPI;
            else if (mmu_dirty && req_op.store)   code = EXC_PME;
        end
    end

    assign excp_valid = req_valid && !flush && (code != EXC_NONE);
    assign excp_code  = excp_valid ? code : EXC_NONE;
    assign mmu_valid  = req_valid && !xlat_held && !flush;
    assign mmu_vtag   = req_addr[31 -: TAG_W];

    assign dc_valid  = req_valid && xlat_ok && (code == EXC_NONE) && !flush &&
                       (count < CW'(OUTSTANDING));
    assign req_ready = dc_valid && dc_addr_ok;

    assign dc_store    = req_op.store;
    assign dc_tag      = mmu_ptag;
    assign dc_index    = req_addr[OFF_W +: IDX_W];
    assign dc_offset   = req_addr[OFF_W-1:0];
    assign dc_size     = req_op.size;
    assign dc_wstrb    = lsu_wstrb(req_op.size, req_addr[1:0]);
    assign dc_uncached = (mmu_mat == 2'd0);

    always_comb begin
        case (req_op.size)
            SZ_B:    dc_wdata = {4{req_wdata[7:0]}};
            SZ_H:    dc_wdata = {2{req_wdata[15:0]}};
            default: dc_wdata = req_wdata;
        endcase
    end

    assign push_ent = '{off: req_addr[1:0], size: req_op.size, sign: req_op.sign, store: req_op.store};
    assign pop      = dc_data_ok && (count != '0);

    lsu_tracker_fifo #(.DEPTH(OUTSTANDING), .T(trk_ent_t)) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .push         (req_ready),
        .din          (push_ent),
        .pop          (pop),
        .flush_mark   (flush),
        .count        (count),
        .head         (head),
        .head_discard (head_discard)
    );

    assign busy       = (count != '0);
    assign resp_valid = pop && !head_discard && !flush;
    assign resp_data  = resp_valid ? lsu_load_fmt(dc_rdata, head) : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            xlat_held    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (req_ready || excp_valid || flush)
                xlat_held <= 1'b0;
            else if (mmu_ok)
                xlat_held <= 1'b1;
            if (dc_data_ok && count == '0)
                protocol_err <= 1'b1;
        end
    end

endmodule
